// File: rtl/bsg_acm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_acm_pkg
//  Description : Shared types and elaboration-time helpers for the
//                Arnold's-cat-map encryptor/decryptor datapaths.
//  Revision    : 1.0 - initial release
// ============================================================================
package bsg_acm_pkg;

    // Decryptor control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } acm_inv_state_e;

    // Width helper that never collapses to zero bits
    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

    // Flat cell index of board coordinate (x,y) on a W-wide board.
    // Used by both the forward and inverse cell arrays so that the
    // two directions agree on the board layout.
    function automatic int cat_idx(input int x, input int y, input int w);
        return y * w + x;
    endfunction

endpackage : bsg_acm_pkg
`default_nettype wire

// File: rtl/bsg_acm_inv_cell_array.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_acm_inv_cell_array
//  Description : Board register plus the inverse cat-map step wiring.
//                A load takes priority over a step; with neither asserted
//                the board holds its value.
//  Revision    : 1.0 - initial release
// ============================================================================
module bsg_acm_inv_cell_array
    import bsg_acm_pkg::*;
#(
    parameter int board_width_p = 8,
    localparam int num_total_cells_lp = board_width_p * board_width_p
) (
    input  logic                          clk_i,
    input  logic [num_total_cells_lp-1:0] data_i,
    input  logic                          load_i,
    input  logic                          step_i,
    output logic [num_total_cells_lp-1:0] data_o
);

    logic [num_total_cells_lp-1:0] r_board;
    logic [num_total_cells_lp-1:0] w_next;

    // Inverse step is a fixed permutation: each destination cell (x,y)
    // gathers from source cell ((x+y) mod W, (x+2y) mod W). All index
    // arithmetic folds away at elaboration.
    for (genvar gy = 0; gy < board_width_p; gy++) begin : g_row
        for (genvar gx = 0; gx < board_width_p; gx++) begin : g_col
            assign w_next[cat_idx(gx, gy, board_width_p)] =
                r_board[cat_idx((gx + gy) % board_width_p,
                                (gx + 2 * gy) % board_width_p,
                                board_width_p)];
        end
    end

    // Board register: load a new board, or advance one inverse iteration
    always_ff @(posedge clk_i) begin
        if (load_i) begin
            r_board <= data_i;
        end else if (step_i) begin
            r_board <= w_next;
        end
    end

    assign data_o = r_board;

endmodule : bsg_acm_inv_cell_array
`default_nettype wire

// File: rtl/bsg_acm_inv.sv
`default_nettype none
// ============================================================================
//  Module      : bsg_acm_inv
//  Description : Arnold's-cat-map decryption engine. Accepts a scrambled
//                board and an iteration count, applies the inverse cat map
//                once per enabled cycle, and presents the recovered board
//                on a valid/yumi interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module bsg_acm_inv
    import bsg_acm_pkg::*;
#(
    // Both parameters are expected to be overridden at instantiation.
    parameter int board_width_p     = 8,
    parameter int max_game_length_p = 8,
    localparam int num_total_cells_lp   = board_width_p * board_width_p,
    localparam int game_length_width_lp = safe_clog2(max_game_length_p + 1)
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            en_i,
    input  logic [num_total_cells_lp-1:0]   data_i,
    input  logic [game_length_width_lp-1:0] frames_i,
    input  logic                            v_i,
    output logic                            ready_o,
    output logic [num_total_cells_lp-1:0]   data_o,
    output logic                            v_o,
    input  logic                            yumi_i
);

    localparam logic [game_length_width_lp-1:0] c_max_count =
        game_length_width_lp'(max_game_length_p);

    acm_inv_state_e                  r_state;
    logic [game_length_width_lp-1:0] r_cnt;
    logic                            r_v;
    logic                            r_ready;

    logic [game_length_width_lp-1:0] w_clamped;
    logic                            w_accept;
    logic                            w_load;
    logic                            w_step;
    logic [num_total_cells_lp-1:0]   w_load_data;

    // Requested iteration count saturated at the configured maximum
    assign w_clamped = (frames_i > c_max_count) ? c_max_count : frames_i;

    // Ready is held low through any reset cycle, even when already idle
    assign ready_o  = r_ready & ~reset_i;
    assign w_accept = v_i & ready_o;

    // Reset reuses the load path to clear the board register to zero
    assign w_load      = reset_i | w_accept;
    assign w_load_data = reset_i ? '0 : data_i;
    assign w_step      = ~reset_i & en_i & (r_state == RUN);

    bsg_acm_inv_cell_array #(
        .board_width_p (board_width_p)
    ) u_cells (
        .clk_i  (clk_i),
        .data_i (w_load_data),
        .load_i (w_load),
        .step_i (w_step),
        .data_o (data_o)
    );

    // Control FSM and iteration counter with registered handshake outputs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_v     <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (v_i) begin
                        r_cnt   <= w_clamped;
                        r_ready <= 1'b0;
                        if (w_clamped != '0) begin
                            r_state <= RUN;
                        end else begin
                            r_state <= DONE;
                            r_v     <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (en_i) begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == game_length_width_lp'(1)) begin
                            r_state <= DONE;
                            r_v     <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // No same-cycle re-accept: ready returns next cycle
                    if (yumi_i) begin
                        r_state <= IDLE;
                        r_v     <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_v     <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign v_o = r_v;

endmodule : bsg_acm_inv
`default_nettype wire
